gb_host: RTL and testbench
==========================

Name: gb_host

Overview:
- Bus initiator (host end) of the ghostbus interface.
- Converts a valid/ready command stream (single or auto-incrementing burst reads/writes) into gb_addr/gb_dout/gb_we cycles.
- Samples gb_din after a fixed read latency and returns read data on a valid/ready response stream.
- Sits between a host transport (UART/Ethernet/JTAG bridge) and the top of the auto-decoded ghostbus tree. Peripheral gb_clk is tied to clk at top level.

Parameters:
- AW, 24, bus address width.
- DW, 32, bus data width.
- LW, 8, width of burst length field; a burst is cmd_len+1 beats, max 2^LW.
- RD_DELAY, 2, cycles from a gb_addr update edge to the gb_din sample edge; legal range 1..15.

Ports:
- clk  input  1  bus clock; all logic is synchronous to it.
- rst  input  1  asynchronous reset, active-high.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command.
- cmd_we  input  1  1 = write, 0 = read.
- cmd_addr  input  AW  start address.
- cmd_wdata  input  DW  write data, repeated on every beat of a write burst.
- cmd_len  input  LW  beats minus one.
- rsp_valid  output  1  read data present.
- rsp_ready  input  1  consumer accepts read data.
- rsp_rdata  output  DW  read data.
- rsp_last  output  1  final beat of a read burst.
- gb_addr  output  AW  bus address.
- gb_dout  output  DW  bus write data (host to peripherals).
- gb_we  output  1  bus write strobe.
- gb_din  input  DW  bus read data (peripherals to host).
- busy  output  1  command in progress.

Behaviour:
- All outputs are registered.
- While rst is high: every output is 0, the FSM is in IDLE, and counters are cleared. The effect is immediate (async), including gb_we.
- cmd_ready rises on the first clk edge after rst deasserts. It is 1 only in IDLE.
- Acceptance occurs at edge T when cmd_valid & cmd_ready. At T the block latches we/addr/wdata/len, drops cmd_ready and sets busy.
- cmd_* is ignored while cmd_ready = 0.
- FSM states: IDLE, WRITE, RD_WAIT, RD_RSP.
- IDLE to WRITE or RD_WAIT on acceptance. At edge T the block drives gb_addr = cmd_addr and gb_dout = cmd_wdata; for writes it also drives gb_we = 1.
- WRITE:
  - gb_we stays 1 for exactly len+1 consecutive cycles.
  - gb_addr increments by 1 per cycle and wraps modulo 2^AW.
  - gb_dout is constant.
  - At the edge ending the last beat: gb_we = 0, go to IDLE, cmd_ready = 1, busy = 0.
  - A single write therefore occupies 1 cycle, and the next command can be accepted 1 cycle later.
  - Writes produce no response.
- RD_WAIT:
  - gb_we = 0 and gb_addr is held.
  - A down-counter loaded with RD_DELAY-1 at the gb_addr update edge counts to 0.
  - At the edge E+RD_DELAY (E = the gb_addr update edge): rsp_rdata <= gb_din, rsp_valid <= 1, rsp_last <= (beat == len), go to RD_RSP.
- RD_RSP:
  - rsp_valid, rsp_rdata, rsp_last and gb_addr are held stable while rsp_ready = 0, for an unbounded stall.
  - At a handshake edge (rsp_valid & rsp_ready):
    - If not last: rsp_valid <= 0, gb_addr <= gb_addr+1 (wrapping), reload the counter, go to RD_WAIT.
    - If last: rsp_valid <= 0, rsp_last <= 0, go to IDLE, cmd_ready <= 1, busy <= 0.
- Minimum read beat period is RD_DELAY+1 cycles with rsp_ready tied high.
- gb_addr and gb_dout hold their last values in IDLE. gb_we is 0 everywhere except WRITE.
- Beat counter is LW bits. cmd_len = 2^LW-1 yields 2^LW beats, with no overflow or early termination.
- Reset mid-burst aborts with no further bus cycles and no partial responses. A rsp_valid pending at reset is dropped.
- busy = (state != IDLE). busy and cmd_ready are never both 1 after reset.

Test Plan:
1. Single write, addr=0x000001, wdata=0xceceface, len=0 -> gb_we high exactly 1 cycle with gb_addr=0x000001 and gb_dout=0xceceface; a model register reads back 0xceceface; cmd_ready returns 1 the next cycle.
2. Write burst at 0xFFFFFE, len=3, wdata=0xA5 -> 4 consecutive gb_we cycles at addresses 0xFFFFFE, 0xFFFFFF, 0x000000, 0x000001; busy is high for exactly 4 cycles.
3. Single read of a model peripheral with registered data (total latency 2) holding 0xcc, RD_DELAY=2 -> rsp_valid rises 2 edges after gb_addr updates with rsp_rdata=0x000000cc and rsp_last=1.
4. Read burst of 4 from a 64-entry model RAM at 0x100 preloaded with i*3, rsp_ready toggling 1,0,0,1 -> responses 0,3,6,9 in order; rsp_rdata and gb_addr stable during stalls; rsp_last on the 4th beat only; no gb_we activity.
5. rst pulsed mid write burst (len=7, after beat 3) and mid read (during RD_RSP stall) -> gb_we and rsp_valid go 0 asynchronously; no further bus beats; cmd_ready is 1 one edge after release.
6. Back-to-back commands with cmd_valid held high (write then read of the same address) -> read returns the just-written value; cmd_valid asserted while busy is not consumed.

Source files
------------

// File: rtl/gb_host.sv
// gb_host: host-side initiator of the ghostbus.
// Turns a valid/ready command stream (single or auto-incrementing burst
// reads/writes) into gb_addr/gb_dout/gb_we bus cycles, and returns read
// data sampled RD_DELAY cycles after each address update on a valid/ready
// response stream.
module gb_host #(
  parameter int unsigned AW       = 24,
  parameter int unsigned DW       = 32,
  parameter int unsigned LW       = 8,
  parameter int unsigned RD_DELAY = 2
) (
  input  logic          clk,
  input  logic          rst,
  // command stream
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_we,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
  input  logic [LW-1:0] cmd_len,
  // response stream
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_last,
  // ghostbus
  output logic [AW-1:0] gb_addr,
  output logic [DW-1:0] gb_dout,
  output logic          gb_we,
  input  logic [DW-1:0] gb_din,
  // status
  output logic          busy
);

  // Read-latency counter is wide enough for the full 1..15 delay range.
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] CNT_RELOAD = CW'(RD_DELAY - 1);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    RD_WAIT,
    RD_RSP
  } state_e;

  state_e          state_q,     state_d;
  logic            cmd_ready_q, cmd_ready_d;
  logic            busy_q,      busy_d;
  logic [AW-1:0]   gb_addr_q,   gb_addr_d;
  logic [DW-1:0]   gb_dout_q,   gb_dout_d;
  logic            gb_we_q,     gb_we_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic            rsp_last_q,  rsp_last_d;
  logic [LW-1:0]   len_q,       len_d;
  logic [LW-1:0]   beat_q,      beat_d;
  logic [CW-1:0]   cnt_q,       cnt_d;

  // Register file for all state and outputs; reset clears everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      gb_addr_q   <= '0;
      gb_dout_q   <= '0;
      gb_we_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_last_q  <= 1'b0;
      len_q       <= '0;
      beat_q      <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      gb_addr_q   <= gb_addr_d;
      gb_dout_q   <= gb_dout_d;
      gb_we_q     <= gb_we_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_last_q  <= rsp_last_d;
      len_q       <= len_d;
      beat_q      <= beat_d;
      cnt_q       <= cnt_d;
    end
  end

  // Next-state and next-output logic; gb_we defaults low so it is only
  // ever high while a write burst is still emitting beats.
  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    busy_d      = busy_q;
    gb_addr_d   = gb_addr_q;
    gb_dout_d   = gb_dout_q;
    gb_we_d     = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_last_d  = rsp_last_q;
    len_d       = len_q;
    beat_d      = beat_q;
    cnt_d       = cnt_q;

    unique case (state_q)
      IDLE: begin
        // cmd_ready comes up on the first edge after reset release
        cmd_ready_d = 1'b1;
        busy_d      = 1'b0;
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          busy_d      = 1'b1;
          gb_addr_d   = cmd_addr;
          gb_dout_d   = cmd_wdata;
          len_d       = cmd_len;
          beat_d      = '0;
          cnt_d       = CNT_RELOAD;
          if (cmd_we) begin
            gb_we_d = 1'b1;
            state_d = WRITE;
          end else begin
            state_d = RD_WAIT;
          end
        end
      end

      WRITE: begin
        if (beat_q == len_q) begin
          state_d     = IDLE;
          cmd_ready_d = 1'b1;
          busy_d      = 1'b0;
        end else begin
          gb_we_d   = 1'b1;
          beat_d    = beat_q + LW'(1);
          gb_addr_d = gb_addr_q + AW'(1);
        end
      end

      RD_WAIT: begin
        if (cnt_q == '0) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = gb_din;
          rsp_last_d  = (beat_q == len_q);
          state_d     = RD_RSP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      RD_RSP: begin
        // everything stays frozen until the consumer takes the beat
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (rsp_last_q) begin
            rsp_last_d  = 1'b0;
            state_d     = IDLE;
            cmd_ready_d = 1'b1;
            busy_d      = 1'b0;
          end else begin
            gb_addr_d = gb_addr_q + AW'(1);
            beat_d    = beat_q + LW'(1);
            cnt_d     = CNT_RELOAD;
            state_d   = RD_WAIT;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs come straight from registers.
  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign gb_addr   = gb_addr_q;
  assign gb_dout   = gb_dout_q;
  assign gb_we     = gb_we_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_last  = rsp_last_q;

endmodule

// File: tb/tb_gb_host.sv
// Testbench for gb_host: directed scenarios plus randomized commands,
// scored against a transaction-level memory model and a 256-word peripheral.
module tb_gb_host;

  localparam int unsigned AW       = 24;
  localparam int unsigned DW       = 32;
  localparam int unsigned LW       = 8;
  localparam int unsigned RD_DELAY = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_we = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [LW-1:0] cmd_len = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_last;
  logic [AW-1:0] gb_addr;
  logic [DW-1:0] gb_dout;
  logic          gb_we;
  logic [DW-1:0] gb_din;
  logic          busy;

  always #5 clk = ~clk;

  gb_host #(.AW(AW), .DW(DW), .LW(LW), .RD_DELAY(RD_DELAY)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_len(cmd_len),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_last(rsp_last),
    .gb_addr(gb_addr), .gb_dout(gb_dout), .gb_we(gb_we), .gb_din(gb_din),
    .busy(busy)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Peripheral: 256 words mirrored over the address space, registered read.
  logic [DW-1:0] pmem [256];
  logic          init_req = 1'b0;
  always @(posedge clk) begin
    if (init_req) begin
      for (int i = 0; i < 256; i++) pmem[i] <= 32'(i * 3);
    end else if (gb_we) begin
      pmem[gb_addr[7:0]] <= gb_dout;
    end
    gb_din <= pmem[gb_addr[7:0]];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: memory contents plus expected bus writes and responses.
  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  typedef struct { logic [DW-1:0] d; logic l; } rsp_t;
  logic [DW-1:0] ref_mem [256];
  wr_t  exp_wr[$];
  rsp_t exp_rsp[$];

  int   rdy_mode = 0;   // 0 always ready, 1 random, 2 pattern, 3 hold off
  logic pat [4];
  int   pat_i    = 0;
  int   busy_cnt = 0;
  int   rise_cyc = 0;
  int   acc_cyc  = 0;

  // Bus/response monitor and response consumer, evaluated mid-cycle.
  initial begin : sink
    logic          r;
    logic          prev_v;
    logic          stall_q;
    logic [DW-1:0] hold_d;
    logic          hold_l;
    logic [AW-1:0] hold_a;
    wr_t           we_e;
    rsp_t          re_e;
    prev_v  = 1'b0;
    stall_q = 1'b0;
    hold_d  = '0;
    hold_l  = 1'b0;
    hold_a  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_q = 1'b0;
        prev_v  = 1'b0;
      end else begin
        chk("busy_ready_exclusive", 64'(busy & cmd_ready), 64'(0));
        if (busy) busy_cnt++;
        if (gb_we) begin
          chk("wr_expected", 64'(exp_wr.size() != 0), 64'(1));
          if (exp_wr.size() != 0) begin
            we_e = exp_wr.pop_front();
            chk("wr_addr", 64'(gb_addr), 64'(we_e.a));
            chk("wr_data", 64'(gb_dout), 64'(we_e.d));
          end
        end
        if (stall_q) begin
          chk("stall_valid", 64'(rsp_valid), 64'(1));
          chk("stall_rdata", 64'(rsp_rdata), 64'(hold_d));
          chk("stall_last", 64'(rsp_last), 64'(hold_l));
          chk("stall_addr", 64'(gb_addr), 64'(hold_a));
        end
        if (rsp_valid && !prev_v) rise_cyc = cyc;
        prev_v = rsp_valid;
        case (rdy_mode)
          0: r = 1'b1;
          1: r = ($urandom_range(0, 3) != 0);
          2: begin
            r = pat[pat_i];
            if (rsp_valid) pat_i = (pat_i + 1) % 4;
          end
          default: r = 1'b0;
        endcase
        rsp_ready = r;
        if (rsp_valid && r) begin
          chk("rsp_expected", 64'(exp_rsp.size() != 0), 64'(1));
          if (exp_rsp.size() != 0) begin
            re_e = exp_rsp.pop_front();
            chk("rsp_rdata", 64'(rsp_rdata), 64'(re_e.d));
            chk("rsp_last", 64'(rsp_last), 64'(re_e.l));
          end
        end
        stall_q = rsp_valid && !r;
        hold_d  = rsp_rdata;
        hold_l  = rsp_last;
        hold_a  = gb_addr;
      end
    end
  end

  // Load both the peripheral and the model with word[i] = 3*i.
  task automatic init_mem();
    init_req = 1'b1;
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'(i * 3);
    @(negedge clk);
    init_req = 1'b0;
  endtask

  // Present one command, update the model, return the cycle after acceptance.
  task automatic send_cmd(input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, input int len, input logic hold);
    int            n;
    logic [AW-1:0] x;
    for (int i = 0; i <= len; i++) begin
      x = a + AW'(i);
      if (we) begin
        exp_wr.push_back('{a: x, d: wd});
        ref_mem[x[7:0]] = wd;
      end else begin
        exp_rsp.push_back('{d: ref_mem[x[7:0]], l: (i == len)});
      end
    end
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = a;
    cmd_wdata = wd;
    cmd_len   = LW'(len);
    n = 0;
    while (!cmd_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) chk("accept_timeout", 64'(n), 64'(0));
    @(posedge clk);
    @(negedge clk);
    acc_cyc = cyc;
    if (!hold) cmd_valid = 1'b0;
  endtask

  // Wait until every expected transfer has been seen and the block is idle.
  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_wr.size() != 0 || exp_rsp.size() != 0 || !cmd_ready) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_done", 64'(n < 20000), 64'(1));
  endtask

  // Pulse reset from wherever we are; aborted work produces nothing more.
  task automatic reset_pulse();
    rst       = 1'b1;
    cmd_valid = 1'b0;
    #1;
    chk("rst_gb_we", 64'(gb_we), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_cmd_ready", 64'(cmd_ready), 64'(0));
    exp_wr.delete();
    exp_rsp.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rel_ready_low", 64'(cmd_ready), 64'(0));
    @(negedge clk);
    chk("rel_ready_high", 64'(cmd_ready), 64'(1));
    repeat (4) @(negedge clk);
    chk("rel_no_beats", 64'(busy | gb_we | rsp_valid), 64'(0));
  endtask

  initial begin : main
    int n;
    int ln;
    logic          we;
    logic [AW-1:0] a;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;

    // reset state
    repeat (2) @(negedge clk);
    chk("reset_gb_addr", 64'(gb_addr), 64'(0));
    chk("reset_gb_dout", 64'(gb_dout), 64'(0));
    chk("reset_rsp_rdata", 64'(rsp_rdata), 64'(0));
    chk("reset_flags", 64'({cmd_ready, busy, gb_we, rsp_valid, rsp_last}), 64'(0));
    rst = 1'b0;
    chk("release_ready_low", 64'(cmd_ready), 64'(0));
    @(negedge clk);
    chk("release_ready_high", 64'(cmd_ready), 64'(1));
    init_mem();

    // 1: single write then read back
    send_cmd(1'b1, 24'h000001, 32'hceceface, 0, 1'b0);
    chk("t1_we_high", 64'(gb_we), 64'(1));
    chk("t1_ready_low", 64'(cmd_ready), 64'(0));
    @(negedge clk);
    chk("t1_we_low", 64'(gb_we), 64'(0));
    chk("t1_ready_back", 64'(cmd_ready), 64'(1));
    send_cmd(1'b0, 24'h000001, '0, 0, 1'b0);
    wait_idle();

    // 2: wrapping write burst, busy length
    busy_cnt = 0;
    send_cmd(1'b1, 24'hFFFFFE, 32'h000000A5, 3, 1'b0);
    wait_idle();
    chk("t2_busy_cycles", 64'(busy_cnt), 64'(4));

    // 3: single read latency (word 0x44 holds 0xcc)
    send_cmd(1'b0, 24'h000044, '0, 0, 1'b0);
    wait_idle();
    chk("t3_latency", 64'(rise_cyc - acc_cyc), 64'(RD_DELAY));

    // 4: read burst with a stalling consumer
    init_mem();
    rdy_mode = 2;
    pat_i    = 0;
    send_cmd(1'b0, 24'h000100, '0, 3, 1'b0);
    wait_idle();
    rdy_mode = 0;

    // 5a: reset in the middle of a write burst
    send_cmd(1'b1, 24'h000020, 32'h12345678, 7, 1'b0);
    n = 0;
    while (exp_wr.size() > 5 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    reset_pulse();
    // 5b: reset while a response is stalled
    rdy_mode = 3;
    send_cmd(1'b0, 24'h000010, '0, 2, 1'b0);
    n = 0;
    while (!rsp_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("t5_rsp_seen", 64'(rsp_valid), 64'(1));
    repeat (2) @(negedge clk);
    #2;
    reset_pulse();
    rdy_mode = 0;
    init_mem();

    // 6: back-to-back with cmd_valid held across busy periods
    send_cmd(1'b1, 24'h0000A0, 32'hdeadbeef, 0, 1'b1);
    send_cmd(1'b0, 24'h0000A0, '0, 0, 1'b1);
    send_cmd(1'b1, 24'h0000B0, 32'h0badf00d, 3, 1'b1);
    send_cmd(1'b0, 24'h0000B2, '0, 1, 1'b0);
    wait_idle();

    // randomized commands
    rdy_mode = 1;
    for (int k = 0; k < 40; k++) begin
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) a = 24'hFFFFF8 + 24'($urandom_range(0, 7));
      else a = 24'($urandom);
      ln = $urandom_range(0, 7);
      send_cmd(we, a, 32'($urandom), ln, (k != 39) && ($urandom_range(0, 1) == 1));
    end
    wait_idle();

    // maximum-length bursts
    busy_cnt = 0;
    send_cmd(1'b1, 24'hFFFF80, 32'h5a5a1234, 255, 1'b0);
    wait_idle();
    chk("max_burst_busy", 64'(busy_cnt), 64'(256));
    send_cmd(1'b0, 24'hFFFF80, '0, 255, 1'b0);
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
